// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one-outstanding-request fetch from an instruction memory port,
// holding each fetched word for decode and discarding responses made stale by redirects.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_req_addr;
  logic [XLEN-1:0]   r_inst;
  logic [XLEN-1:0]   r_inst_pc;
  logic [XLEN-1:0]   r_fetch_count;
  logic              r_kill;

  logic [XLEN-1:0]   w_redirect_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic              w_deliver;

  assign w_redirect_pc = redirect_pc & ~XLEN'(3);
  assign w_deliver     = (r_state == S_HOLD) && inst_ready;

  // Next fetch PC: a redirect always wins over sequential advance.
  always_comb begin
    w_pc_nxt = r_fetch_pc;
    if (redirect_valid) begin
      w_pc_nxt = w_redirect_pc;
    end else if (w_deliver) begin
      w_pc_nxt = r_fetch_pc + XLEN'(4);
    end
  end

  // r_req_addr is only reloaded when entering REQ, so an unaccepted request stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_req_addr    <= RESET_PC;
      r_inst        <= '0;
      r_inst_pc     <= '0;
      r_fetch_count <= '0;
      r_kill        <= 1'b0;
    end else begin
      r_fetch_pc <= w_pc_nxt;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_REQ;
          r_req_addr <= w_pc_nxt;
        end
        S_REQ: begin
          if (redirect_valid) begin
            r_kill <= 1'b1;
          end
          if (imem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (r_kill || redirect_valid) begin
              r_kill     <= 1'b0;
              r_state    <= S_REQ;
              r_req_addr <= w_pc_nxt;
            end else begin
              r_inst    <= imem_resp_data;
              r_inst_pc <= r_fetch_pc;
              r_state   <= S_HOLD;
            end
          end else if (redirect_valid) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || inst_ready) begin
            r_state    <= S_REQ;
            r_req_addr <= w_pc_nxt;
          end
          if (inst_ready) begin
            r_fetch_count <= r_fetch_count + XLEN'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_req_addr;
  assign inst_valid     = (r_state == S_HOLD);
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: latency-configurable memory model plus a scoreboard of expected
// deliveries (pc, word) checked whenever decode accepts an instruction.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DATA_KEY = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .fetch_count(fetch_count)
  );

  // Memory model: response appears mem_lat cycles after the accepting cycle.
  int          mem_lat = 1;
  int          mem_cnt = 0;
  bit          mem_pend = 1'b0;
  int          mem_accepts = 0;
  logic [31:0] mem_addr = '0;

  always @(posedge clk) begin
    imem_resp_valid <= 1'b0;
    if (reset) begin
      mem_pend = 1'b0;
    end else begin
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= mem_addr ^ DATA_KEY;
          mem_pend = 1'b0;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_accepts++;
        mem_addr = imem_req_addr;
        mem_cnt  = mem_lat - 1;
        if (mem_cnt == 0) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= imem_req_addr ^ DATA_KEY;
        end else begin
          mem_pend = 1'b1;
        end
      end
    end
  end

  // Scoreboard of expected deliveries.
  logic [31:0] exp_pc_q[$];

  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      n_checks++;
      if (exp_pc_q.size() == 0) begin
        n_fail++;
        $display("FAIL deliver_unexpected: got pc=%h inst=%h, queue empty", inst_pc, inst);
      end else begin
        logic [31:0] p;
        p = exp_pc_q.pop_front();
        if (inst_pc !== p || inst !== (p ^ DATA_KEY)) begin
          n_fail++;
          $display("FAIL deliver: got pc=%h inst=%h, expected pc=%h inst=%h",
                   inst_pc, inst, p, p ^ DATA_KEY);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat = 1;
    exp_pc_q.delete();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    bit found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (inst_valid) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_valid_timeout: inst_valid not seen in %0d cycles", maxc);
    end
  endtask

  task automatic wait_deliver(input int maxc, input bit drop_ready);
    bit found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_deliver_timeout: no delivery in %0d cycles", maxc);
    end
    if (drop_ready) begin
      cyc();
      inst_ready = 1'b0;
    end
  endtask

  task automatic wait_accept(input int maxc, output logic [31:0] addr);
    bit found = 1'b0;
    addr = 'x;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        found = 1'b1;
        addr  = imem_req_addr;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_accept_timeout: no request accepted in %0d cycles", maxc);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check32("rst_inst_valid", 32'(inst_valid), 32'd0);
    check32("rst_inst", inst, 32'd0);
    check32("rst_inst_pc", inst_pc, 32'd0);
    check32("rst_fetch_count", fetch_count, 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check32("rst_first_cycle_no_req", 32'(imem_req_valid), 32'd0);
    cyc();
    @(negedge clk);
    check32("rst_second_cycle_req", 32'(imem_req_valid), 32'd1);
    check32("rst_first_addr", imem_req_addr, RESET_PC);
  endtask

  task automatic test_sequential();
    int vcyc[3];
    int nv = 0;
    int nreq = 0;
    do_reset();
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) exp_pc_q.push_back(RESET_PC + 32'(4 * k));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && nreq < 3) begin
        check32("seq_req_addr", imem_req_addr, RESET_PC + 32'(4 * nreq));
        nreq++;
      end
      if (inst_valid) begin
        vcyc[nv] = c;
        nv++;
        if (nv == 3) break;
      end
    end
    cyc();
    inst_ready = 1'b0;
    check32("seq_num_valid", 32'(nv), 32'd3);
    check32("seq_first_valid_cycle", 32'(vcyc[0]), 32'd3);
    check32("seq_spacing_1", 32'(vcyc[1] - vcyc[0]), 32'd3);
    check32("seq_spacing_2", 32'(vcyc[2] - vcyc[1]), 32'd3);
    @(negedge clk);
    check32("seq_fetch_count", fetch_count, 32'd3);
    check32("seq_queue_drained", 32'(exp_pc_q.size()), 32'd0);
  endtask

  task automatic test_backpressure();
    logic [31:0] i0, p0;
    int a0;
    do_reset();
    exp_pc_q.push_back(RESET_PC);
    wait_valid(10);
    i0 = inst;
    p0 = inst_pc;
    a0 = mem_accepts;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check32("bp_inst_stable", inst, i0);
      check32("bp_pc_stable", inst_pc, p0);
      check32("bp_valid_held", 32'(inst_valid), 32'd1);
      check32("bp_no_req", 32'(imem_req_valid), 32'd0);
      check32("bp_count_same", fetch_count, 32'd0);
    end
    cyc();
    inst_ready = 1'b1;
    wait_deliver(5, 1'b1);
    @(negedge clk);
    check32("bp_count_after", fetch_count, 32'd1);
    check32("bp_no_accept_in_hold", 32'(mem_accepts), 32'(a0));
    check32("bp_next_req_valid", 32'(imem_req_valid), 32'd1);
    check32("bp_next_req_addr", imem_req_addr, RESET_PC + 32'd4);
  endtask

  task automatic test_req_stall();
    int a0;
    do_reset();
    inst_ready = 1'b1;
    exp_pc_q.push_back(RESET_PC);
    wait_deliver(10, 1'b0);
    cyc();
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    a0 = mem_accepts;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check32("stall_req_valid", 32'(imem_req_valid), 32'd1);
      check32("stall_req_addr", imem_req_addr, RESET_PC + 32'd4);
    end
    cyc();
    check32("stall_no_accept", 32'(mem_accepts), 32'(a0));
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    exp_pc_q.push_back(RESET_PC + 32'd4);
    wait_deliver(10, 1'b1);
    check32("stall_one_accept", 32'(mem_accepts), 32'(a0 + 1));
  endtask

  task automatic test_redirect_req();
    logic [31:0] a;
    do_reset();
    imem_req_ready = 1'b0;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_2000;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    check32("rreq_addr_stable", imem_req_addr, RESET_PC);
    cyc();
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    exp_pc_q.push_back(32'h8000_2000);
    wait_accept(5, a);
    check32("rreq_old_req_completes", a, RESET_PC);
    wait_accept(10, a);
    check32("rreq_new_req", a, 32'h8000_2000);
    wait_deliver(10, 1'b1);
    check32("rreq_count", fetch_count, 32'd1);
  endtask

  task automatic test_redirect_wait();
    logic [31:0] a;
    do_reset();
    inst_ready = 1'b1;
    mem_lat = 3;
    wait_accept(10, a);
    check32("rwait_first_req", a, RESET_PC);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0103;
    exp_pc_q.push_back(32'h8000_0100);
    cyc();
    redirect_valid = 1'b0;
    wait_accept(10, a);
    check32("rwait_next_req", a, 32'h8000_0100);
    wait_deliver(10, 1'b1);
    check32("rwait_count", fetch_count, 32'd1);
  endtask

  task automatic test_redirect_hold();
    do_reset();
    exp_pc_q.push_back(RESET_PC);
    wait_valid(10);
    cyc();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1000;
    cyc();
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    check32("rhold_count", fetch_count, 32'd1);
    check32("rhold_req_valid", 32'(imem_req_valid), 32'd1);
    check32("rhold_req_addr", imem_req_addr, 32'h8000_1000);
    check32("rhold_inst_dropped", 32'(inst_valid), 32'd0);
    cyc();
    exp_pc_q.push_back(32'h8000_1000);
    inst_ready = 1'b1;
    wait_deliver(10, 1'b1);
    check32("rhold_count2", fetch_count, 32'd2);
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] a;
    do_reset();
    inst_ready = 1'b1;
    exp_pc_q.push_back(RESET_PC);
    wait_deliver(10, 1'b0);
    cyc();
    mem_lat = 3;
    inst_ready = 1'b0;
    wait_accept(5, a);
    check32("rst_wait_req", a, RESET_PC + 32'd4);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mem_lat = 1;
    inst_ready = 1'b1;
    exp_pc_q.push_back(RESET_PC);
    @(negedge clk);
    check32("rst_wait_req_valid", 32'(imem_req_valid), 32'd0);
    check32("rst_wait_inst_valid", 32'(inst_valid), 32'd0);
    check32("rst_wait_count", fetch_count, 32'd0);
    wait_accept(5, a);
    check32("rst_wait_restart", a, RESET_PC);
    wait_deliver(10, 1'b1);
    check32("rst_wait_count_after", fetch_count, 32'd1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_req_stall();
    test_redirect_req();
    test_redirect_wait();
    test_redirect_hold();
    test_reset_in_wait();
    cyc();
    check32("final_queue_empty", 32'(exp_pc_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
